bifurcation_sweep_ctrl: RTL



---
 rtl/chaos_pkg.sv | 27 ++
 rtl/x_to_row.sv | 27 ++
 rtl/bifurcation_sweep_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/chaos_pkg.sv
// Shared definitions for the chaos plotters.
// Holds the fixed-point operand widths (x is Q1.16, mu is Q2.16), the sweep FSM state type,
// the pixel colours and the default per-column x seed.
package chaos_pkg;

    localparam int unsigned X_W   = 17;
    localparam int unsigned MU_W  = 18;
    localparam int unsigned ROW_W = 10;
    localparam int unsigned COL_W = 10;

    localparam logic [X_W-1:0] X_SEED_DEF = 17'h08240;

    localparam logic [2:0] PIX_ON  = 3'b111;
    localparam logic [2:0] PIX_OFF = 3'b000;

    typedef enum logic [2:0] {
        StIdle,
        StSeed,
        StIssue,
        StWait,
        StPlot,
        StNext,
        StDone,
        StClear
    } state_e;

endpackage

// File: rtl/x_to_row.sv
// Maps a Q1.16 value x in [0, 2) onto a row index 0..V_RES-1.
// Any x >= 1.0 saturates to the top index V_RES-1. Purely combinational.
// Ports:
//   x_i   : Q1.16 input value
//   row_o : floor(frac(x) * V_RES), or V_RES-1 when x >= 1.0
module x_to_row
    import chaos_pkg::*;
#(
    parameter int unsigned V_RES = 480
) (
    input  logic [X_W-1:0]   x_i,
    output logic [ROW_W-1:0] row_o
);

    logic [25:0] prod;

    always_comb begin
        prod = {10'd0, x_i[15:0]} * 26'(V_RES);
        if (x_i[X_W-1]) begin
            row_o = ROW_W'(V_RES - 1);
        end else begin
            // prod < 2^16 * V_RES, so the high part is always < V_RES
            row_o = ROW_W'(prod >> 16);
        end
    end

endmodule

// File: rtl/bifurcation_sweep_ctrl.sv
// Bifurcation diagram sequencer.
// Sweeps one mu per screen column (mu_start, mu_start+mu_step, ...). For each column it seeds x,
// runs WARMUP unplotted iterations through the shared logistic unit, then PLOT_ITERS iterations
// whose results are written as lit pixels to the framebuffer.
// Optional build macro SWEEP_CLEAR_EN: clears the whole framebuffer (row-major) after start,
// before the first column is computed.
// Ports:
//   CLK, RST            : clock, synchronous active-high reset
//   start, abort        : start pulse (IDLE/DONE only), abort level (wins over start)
//   mu_start, mu_step   : Q2.16 mu range, sampled on start
//   fn_req/fn_x/fn_mu   : request and operands to the logistic unit, held until fn_ack
//   fn_ack/fn_y         : result strobe and Q1.16 result
//   fb_we/fb_ready      : pixel write handshake
//   fb_col/fb_row/fb_data : pixel address and colour
//   busy, done          : status
module bifurcation_sweep_ctrl
    import chaos_pkg::*;
#(
    parameter int unsigned     H_RES      = 640,
    parameter int unsigned     V_RES      = 480,
    parameter int unsigned     WARMUP     = 64,
    parameter int unsigned     PLOT_ITERS = 128,
    parameter logic [X_W-1:0]  X_SEED     = X_SEED_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              abort,
    input  logic [MU_W-1:0]   mu_start,
    input  logic [MU_W-1:0]   mu_step,
    output logic              fn_req,
    output logic [X_W-1:0]    fn_x,
    output logic [MU_W-1:0]   fn_mu,
    input  logic              fn_ack,
    input  logic [X_W-1:0]    fn_y,
    output logic              fb_we,
    input  logic              fb_ready,
    output logic [COL_W-1:0]  fb_col,
    output logic [ROW_W-1:0]  fb_row,
    output logic [2:0]        fb_data,
    output logic              busy,
    output logic              done
);

    localparam int unsigned ITER_TOT = WARMUP + PLOT_ITERS;
    localparam int unsigned ITER_W   = $clog2(ITER_TOT + 1);

    localparam logic [ITER_W-1:0] WARMUP_L   = ITER_W'(WARMUP);
    localparam logic [ITER_W-1:0] ITER_TOT_L = ITER_W'(ITER_TOT);
    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(V_RES - 1);

    state_e              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [MU_W-1:0]     mu_q, mu_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [ITER_W-1:0]   iter_q, iter_d;
    logic [ROW_W-1:0]    map_row;
`ifdef SWEEP_CLEAR_EN
    logic [ROW_W-1:0]    clr_row_q, clr_row_d;
`endif

    x_to_row #(
        .V_RES (V_RES)
    ) u_x_to_row (
        .x_i   (x_q),
        .row_o (map_row)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        mu_d    = mu_q;
        x_d     = x_q;
        iter_d  = iter_q;
`ifdef SWEEP_CLEAR_EN
        clr_row_d = clr_row_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    col_d = '0;
                    mu_d  = mu_start;
`ifdef SWEEP_CLEAR_EN
                    clr_row_d = '0;
                    state_d   = StClear;
`else
                    state_d   = StSeed;
`endif
                end
            end
            StSeed: begin
                x_d     = X_SEED;
                iter_d  = '0;
                state_d = StIssue;
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (fn_ack) begin
                    x_d    = fn_y;
                    iter_d = iter_q + ITER_W'(1);
                    // iter_q still counts completed iterations before this result
                    state_d = (iter_q < WARMUP_L) ? StIssue : StPlot;
                end
            end
            StPlot: begin
                if (fb_ready) begin
                    state_d = (iter_q == ITER_TOT_L) ? StNext : StIssue;
                end
            end
            StNext: begin
                if (col_q == COL_LAST) begin
                    state_d = StDone;
                end else begin
                    col_d   = col_q + COL_W'(1);
                    mu_d    = mu_q + mu_step;
                    state_d = StSeed;
                end
            end
`ifdef SWEEP_CLEAR_EN
            StClear: begin
                if (fb_ready) begin
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (clr_row_q == ROW_LAST) begin
                            state_d = StSeed;
                        end else begin
                            clr_row_d = clr_row_q + ROW_W'(1);
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
`endif
            default: state_d = StIdle;
        endcase
        if (abort) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            col_q   <= '0;
            mu_q    <= '0;
            x_q     <= X_SEED;
            iter_q  <= '0;
`ifdef SWEEP_CLEAR_EN
            clr_row_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            mu_q    <= mu_d;
            x_q     <= x_d;
            iter_q  <= iter_d;
`ifdef SWEEP_CLEAR_EN
            clr_row_q <= clr_row_d;
`endif
        end
    end

    // Outputs decoded from registered state, so they stay stable while waiting on a handshake
    always_comb begin
        fn_req  = (state_q == StIssue) || (state_q == StWait);
        fn_x    = x_q;
        fn_mu   = mu_q;
        fb_we   = 1'b0;
        fb_col  = '0;
        fb_row  = '0;
        fb_data = PIX_OFF;
        busy    = (state_q != StIdle) && (state_q != StDone);
        done    = (state_q == StDone);
        if (state_q == StPlot) begin
            fb_we   = 1'b1;
            fb_col  = col_q;
            fb_row  = ROW_LAST - map_row;
            fb_data = PIX_ON;
        end
`ifdef SWEEP_CLEAR_EN
        if (state_q == StClear) begin
            fb_we   = 1'b1;
            fb_col  = col_q;
            fb_row  = clr_row_q;
            fb_data = PIX_OFF;
        end
`endif
    end

endmodule
